// File: rtl/reg_writeback_pkg.sv
// Shared widths, forward-select codes and the commit-source enum for the write-back stage.
package reg_writeback_pkg;

    localparam int REG_DATA_WIDTH    = 16;
    localparam int REG_NUM_WIDTH     = 4;
    localparam int NUM_REG           = 16;
    localparam int FIFO_DEPTH        = 2;
    localparam int REG_FORWARD_WIDTH = 2;

    localparam logic [1:0] REG_FORWARD_REG_FILE = 2'b00;
    localparam logic [1:0] REG_FORWARD_WB       = 2'b01;
    localparam logic [1:0] REG_FORWARD_R0       = 2'b10;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FIFO,
        SRC_MD,
        SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO buffering ALU results while mul/div owns the write port.
module wb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign rdata  = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (doPop) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared on reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: arbitrates ALU and mul/div results onto the register-file write port,
// drives the R0 side port, flags illegal destinations and produces read-port forward selects.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int REG_DATA_WIDTH    = reg_writeback_pkg::REG_DATA_WIDTH,
    parameter int REG_NUM_WIDTH     = reg_writeback_pkg::REG_NUM_WIDTH,
    parameter int NUM_REG           = reg_writeback_pkg::NUM_REG,
    parameter int FIFO_DEPTH        = reg_writeback_pkg::FIFO_DEPTH,
    parameter int REG_FORWARD_WIDTH = reg_writeback_pkg::REG_FORWARD_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_NUM_WIDTH-1:0]     alu_rn,
    input  logic [REG_DATA_WIDTH-1:0]    alu_data,
    input  logic                         md_valid,
    output logic                         md_ready,
    input  logic [REG_NUM_WIDTH-1:0]     md_rn,
    input  logic [REG_DATA_WIDTH-1:0]    md_lo,
    input  logic [REG_DATA_WIDTH-1:0]    md_hi,
    input  logic                         md_wr0,
    input  logic [REG_NUM_WIDTH-1:0]     rn_1,
    input  logic [REG_NUM_WIDTH-1:0]     rn_2,
    output logic                         wr,
    output logic [REG_NUM_WIDTH-1:0]     wrn,
    output logic [REG_DATA_WIDTH-1:0]    wrd,
    output logic                         wr0,
    output logic [REG_DATA_WIDTH-1:0]    r0d,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
    output logic                         exception
);

    localparam int ENTRY_W = REG_NUM_WIDTH + REG_DATA_WIDTH;

    wb_src_e                     src;
    logic                        fifoFull;
    logic                        fifoEmpty;
    logic                        fifoPush;
    logic                        fifoPop;
    logic [ENTRY_W-1:0]          fifoHead;
    logic [REG_NUM_WIDTH-1:0]    commitRn;
    logic [REG_DATA_WIDTH-1:0]   commitLo;
    logic                        commitLegal;

    logic                        wr_q, wr_d;
    logic [REG_NUM_WIDTH-1:0]    wrn_q, wrn_d;
    logic [REG_DATA_WIDTH-1:0]   wrd_q, wrd_d;
    logic                        wr0_q, wr0_d;
    logic [REG_DATA_WIDTH-1:0]   r0d_q, r0d_d;
    logic                        exception_q, exception_d;

    // A full buffer must drain before mul/div may commit, otherwise the ALU would stall forever.
    always_comb begin
        src = SRC_NONE;
        if (fifoFull) begin
            src = SRC_FIFO;
        end else if (md_valid) begin
            src = SRC_MD;
        end else if (!fifoEmpty) begin
            src = SRC_FIFO;
        end else if (alu_valid) begin
            src = SRC_ALU;
        end
    end

    assign alu_ready = rst & ~fifoFull;
    assign md_ready  = rst & ~fifoFull;
    assign fifoPush  = alu_valid & alu_ready & (src != SRC_ALU);
    assign fifoPop   = rst & (src == SRC_FIFO);

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata ({alu_rn, alu_data}),
        .rdata (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_comb begin
        commitRn = alu_rn;
        commitLo = alu_data;
        unique case (src)
            SRC_FIFO: {commitRn, commitLo} = fifoHead;
            SRC_MD: begin
                commitRn = md_rn;
                commitLo = md_lo;
            end
            default: ;
        endcase
        commitLegal = (32'(commitRn) < NUM_REG);

        wr_d        = 1'b0;
        wrn_d       = wrn_q;
        wrd_d       = wrd_q;
        wr0_d       = 1'b0;
        r0d_d       = r0d_q;
        exception_d = exception_q;
        if (src != SRC_NONE) begin
            wr_d  = commitLegal;
            wrn_d = commitRn;
            wrd_d = commitLo;
            if (!commitLegal) begin
                exception_d = 1'b1;
            end
        end
        // The R0 side write rides along even when the main destination is illegal.
        if (src == SRC_MD) begin
            wr0_d = md_wr0;
            r0d_d = md_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q        <= 1'b0;
            wrn_q       <= '0;
            wrd_q       <= '0;
            wr0_q       <= 1'b0;
            r0d_q       <= '0;
            exception_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            wrn_q       <= wrn_d;
            wrd_q       <= wrd_d;
            wr0_q       <= wr0_d;
            r0d_q       <= r0d_d;
            exception_q <= exception_d;
        end
    end

    assign wr        = wr_q;
    assign wrn       = wrn_q;
    assign wrd       = wrd_q;
    assign wr0       = wr0_q;
    assign r0d       = r0d_q;
    assign exception = exception_q;

    // R0 beats WB so the forwarded value matches the register file's write ordering.
    always_comb begin
        reg_forward_1 = REG_FORWARD_WIDTH'(REG_FORWARD_REG_FILE);
        if (wr0_q && (rn_1 == '0)) begin
            reg_forward_1 = REG_FORWARD_WIDTH'(REG_FORWARD_R0);
        end else if (wr_q && (wrn_q == rn_1)) begin
            reg_forward_1 = REG_FORWARD_WIDTH'(REG_FORWARD_WB);
        end

        reg_forward_2 = REG_FORWARD_WIDTH'(REG_FORWARD_REG_FILE);
        if (wr0_q && (rn_2 == '0)) begin
            reg_forward_2 = REG_FORWARD_WIDTH'(REG_FORWARD_R0);
        end else if (wr_q && (wrn_q == rn_2)) begin
            reg_forward_2 = REG_FORWARD_WIDTH'(REG_FORWARD_WB);
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a queue-based reference model predicts every commit,
// a free-running monitor pops predictions whenever the DUT strobes a write.
module tb_reg_writeback;

    localparam int DW      = 16;
    localparam int NW      = 4;
    localparam int NREG    = 8;
    localparam int DEPTH   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [NW-1:0] alu_rn = '0;
    logic [DW-1:0] alu_data = '0;
    logic          md_valid = 1'b0;
    logic          md_ready;
    logic [NW-1:0] md_rn = '0;
    logic [DW-1:0] md_lo = '0;
    logic [DW-1:0] md_hi = '0;
    logic          md_wr0 = 1'b0;
    logic [NW-1:0] rn_1 = '0;
    logic [NW-1:0] rn_2 = '0;
    logic          wr;
    logic [NW-1:0] wrn;
    logic [DW-1:0] wrd;
    logic          wr0;
    logic [DW-1:0] r0d;
    logic [1:0]    reg_forward_1;
    logic [1:0]    reg_forward_2;
    logic          exception;

    reg_writeback #(
        .REG_DATA_WIDTH    (DW),
        .REG_NUM_WIDTH     (NW),
        .NUM_REG           (NREG),
        .FIFO_DEPTH        (DEPTH),
        .REG_FORWARD_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rn        (alu_rn),
        .alu_data      (alu_data),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rn         (md_rn),
        .md_lo         (md_lo),
        .md_hi         (md_hi),
        .md_wr0        (md_wr0),
        .rn_1          (rn_1),
        .rn_2          (rn_2),
        .wr            (wr),
        .wrn           (wrn),
        .wrd           (wrd),
        .wr0           (wr0),
        .r0d           (r0d),
        .reg_forward_1 (reg_forward_1),
        .reg_forward_2 (reg_forward_2),
        .exception     (exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] rn;
        logic [DW-1:0] data;
    } aluEntry_t;

    typedef struct {
        logic          wr;
        logic [NW-1:0] wrn;
        logic [DW-1:0] wrd;
        logic          wr0;
        logic [DW-1:0] r0d;
    } commit_t;

    aluEntry_t aluQueue[$];
    commit_t   scoreboard[$];

    logic          mWr = 1'b0;
    logic [NW-1:0] mWrn = '0;
    logic [DW-1:0] mWrd = '0;
    logic          mWr0 = 1'b0;
    logic [DW-1:0] mR0d = '0;
    logic          mExc = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] fwdModel(input logic [NW-1:0] rn);
        if (mWr0 && rn == 0) return 32'd2;
        if (mWr && mWrn == rn) return 32'd1;
        return 32'd0;
    endfunction

    // Reference model: decides what the DUT must do at the coming rising edge.
    task automatic modelStep();
        bit        isFull;
        bit        have;
        bit        bypass;
        aluEntry_t e;
        commit_t   c;
        logic      cW0;
        logic [DW-1:0] cHi;
        logic [NW-1:0] cRn;
        logic [DW-1:0] cLo;
        bit        legal;

        isFull = (aluQueue.size() == DEPTH);
        checkOutput("alu_ready", {31'b0, alu_ready}, {31'b0, rst && !isFull});
        checkOutput("md_ready", {31'b0, md_ready}, {31'b0, rst && !isFull});
        checkOutput("reg_forward_1", {30'b0, reg_forward_1}, fwdModel(rn_1));
        checkOutput("reg_forward_2", {30'b0, reg_forward_2}, fwdModel(rn_2));

        if (!rst) begin
            aluQueue.delete();
            mWr = 0; mWrn = '0; mWrd = '0; mWr0 = 0; mR0d = '0; mExc = 0;
            return;
        end

        have = 0; bypass = 0; cW0 = 0; cHi = '0; cRn = '0; cLo = '0;
        if (isFull) begin
            e = aluQueue.pop_front();
            have = 1; cRn = e.rn; cLo = e.data;
        end else if (md_valid) begin
            have = 1; cRn = md_rn; cLo = md_lo; cW0 = md_wr0; cHi = md_hi;
        end else if (aluQueue.size() > 0) begin
            e = aluQueue.pop_front();
            have = 1; cRn = e.rn; cLo = e.data;
        end else if (alu_valid) begin
            have = 1; bypass = 1; cRn = alu_rn; cLo = alu_data;
        end

        if (alu_valid && !isFull && !bypass) begin
            e.rn = alu_rn; e.data = alu_data;
            aluQueue.push_back(e);
        end

        if (have) begin
            legal = (cRn < NREG);
            mWr = legal; mWrn = cRn; mWrd = cLo; mWr0 = cW0;
            if (cW0) mR0d = cHi;
            if (!legal) mExc = 1;
            if (legal || cW0) begin
                c.wr = legal; c.wrn = cRn; c.wrd = cLo; c.wr0 = cW0; c.r0d = cHi;
                scoreboard.push_back(c);
            end
        end else begin
            mWr = 0; mWr0 = 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic av, input logic [NW-1:0] arn,
                                 input logic [DW-1:0] ad, input logic mv, input logic [NW-1:0] mrn,
                                 input logic [DW-1:0] mlo, input logic [DW-1:0] mhi, input logic mw0,
                                 input logic [NW-1:0] r1, input logic [NW-1:0] r2);
        @(negedge clk);
        rst = r; alu_valid = av; alu_rn = arn; alu_data = ad;
        md_valid = mv; md_rn = mrn; md_lo = mlo; md_hi = mhi; md_wr0 = mw0;
        rn_1 = r1; rn_2 = r2;
        #1;
        modelStep();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    endtask

    // Monitor: pops a prediction every time the DUT strobes either write port.
    initial begin
        commit_t e;
        forever begin
            @(posedge clk);
            #1;
            checkOutput("exception", {31'b0, exception}, {31'b0, mExc});
            checkOutput("wr_strobe", {31'b0, wr}, {31'b0, mWr});
            if (wr || wr0) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_write", {31'b0, wr || wr0}, 32'd0);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("wr", {31'b0, wr}, {31'b0, e.wr});
                    checkOutput("wr0", {31'b0, wr0}, {31'b0, e.wr0});
                    if (e.wr) begin
                        checkOutput("wrn", {28'b0, wrn}, {28'b0, e.wrn});
                        checkOutput("wrd", {16'b0, wrd}, {16'b0, e.wrd});
                    end
                    if (e.wr0) checkOutput("r0d", {16'b0, r0d}, {16'b0, e.r0d});
                end
            end
        end
    end

    initial begin
        $display("[TB] reset with alu_valid held high");
        applyStimulus(0, 1, 3, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        checkOutput("reset_wrn", {28'b0, wrn}, {28'b0, mWrn});
        checkOutput("reset_wrd", {16'b0, wrd}, {16'b0, mWrd});
        checkOutput("reset_r0d", {16'b0, r0d}, {16'b0, mR0d});
        checkOutput("reset_wr0", {31'b0, wr0}, {31'b0, mWr0});

        $display("[TB] ALU bypass");
        applyStimulus(1, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 3, 0);
        idle(2);

        $display("[TB] mul/div priority over ALU");
        applyStimulus(1, 1, 2, 16'h0BBB, 1, 5, 16'h00AA, 16'h0001, 1, 5, 0);
        idle(3);

        $display("[TB] full buffer drains ahead of mul/div");
        applyStimulus(1, 1, 1, 16'hA001, 1, 6, 16'h6001, 16'h0, 0, 1, 6);
        applyStimulus(1, 1, 2, 16'hA002, 1, 6, 16'h6002, 16'h0, 0, 2, 6);
        applyStimulus(1, 1, 3, 16'hA003, 1, 6, 16'h6003, 16'h0, 0, 3, 6);
        applyStimulus(1, 1, 3, 16'hA003, 1, 6, 16'h6004, 16'h0, 0, 3, 6);
        applyStimulus(1, 0, 0, 16'h0, 1, 7, 16'h6005, 16'h0, 0, 7, 0);
        idle(4);

        $display("[TB] forwarding");
        applyStimulus(1, 0, 0, 0, 1, 4, 16'h4444, 16'hBEEF, 1, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        idle(1);

        $display("[TB] illegal destination and reset mid-drain");
        applyStimulus(1, 1, 9, 16'h9999, 0, 0, 0, 0, 0, 9, 0);
        idle(2);
        applyStimulus(1, 1, 1, 16'hC001, 1, 3, 16'h3003, 16'h0, 0, 1, 3);
        applyStimulus(1, 1, 2, 16'hC002, 1, 3, 16'h3004, 16'h0, 0, 2, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        idle(4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 60) != 0),
                          ($urandom_range(0, 2) != 0), NW'($urandom_range(0, 9)), DW'($urandom),
                          ($urandom_range(0, 2) == 0), NW'($urandom_range(0, 9)), DW'($urandom),
                          DW'($urandom), 1'($urandom), NW'($urandom_range(0, 9)), NW'($urandom_range(0, 9)));
        end
        idle(DEPTH + 4);
        checkOutput("scoreboard_drained", scoreboard.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
